// File: rtl/nn_parameters_pkg.sv
// rtl/nn_parameters_pkg.sv - shared sizes, fixed-point type and LFSR step for the NN dropout stage
package nn_parameters;

   localparam int OUT_SIZE_1   = 128;
   localparam int DATA_W       = 16;
   localparam int DROP_RATE_Q8 = 64;
   localparam int SCALE_Q8     = 341;
   localparam logic [15:0] LFSR_SEED   = 16'hACE1;
   localparam logic [15:0] GALOIS_MASK = 16'hB400;

   typedef logic signed [15:0] fixed_t;

   // Right-shifting Galois form: the bit shifted out decides whether the tap mask is folded back in.
   function automatic logic [15:0] lfsr_step(input logic [15:0] state);
      return {1'b0, state[15:1]} ^ (state[0] ? GALOIS_MASK : 16'h0000);
   endfunction

endpackage

// File: rtl/dropout_lane.sv
// rtl/dropout_lane.sv - one combinational dropout lane: drop, scale by 1/(1-p) in Q8.8, saturate
module dropout_lane #(
   parameter int DATA_W       = nn_parameters::DATA_W,
   parameter int DROP_RATE_Q8 = nn_parameters::DROP_RATE_Q8,
   parameter int SCALE_Q8     = nn_parameters::SCALE_Q8
) (
   input  logic signed [DATA_W-1:0] x,
   input  logic        [7:0]        r,
   input  logic                     train_en,
   output logic signed [DATA_W-1:0] y
);

   localparam int PW = 2 * DATA_W;
   localparam logic signed [PW-1:0] SCALE = PW'(SCALE_Q8);
   localparam logic signed [PW-1:0] MAX_V = PW'((1 << (DATA_W - 1)) - 1);
   localparam logic signed [PW-1:0] MIN_V = ~MAX_V;
   localparam logic        [8:0]    DROP  = 9'(DROP_RATE_Q8);

   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] scaled;

   always_comb begin
      prod   = $signed({{DATA_W{x[DATA_W-1]}}, x}) * SCALE;
      // Arithmetic shift floors toward -inf, dropping the Q8 fraction of the scale factor.
      scaled = prod >>> 8;
      y      = x;
      if (train_en) begin
         if ({1'b0, r} < DROP)
            y = '0;
         else if (scaled > MAX_V)
            y = MAX_V[DATA_W-1:0];
         else if (scaled < MIN_V)
            y = MIN_V[DATA_W-1:0];
         else
            y = scaled[DATA_W-1:0];
      end
   end

endmodule

// File: rtl/nn_dropout_layer_1.sv
// rtl/nn_dropout_layer_1.sv - registered dropout stage after dense layer 1 with LFSR-driven lane masks
module nn_dropout_layer_1 #(
   parameter int          OUT_SIZE_1   = nn_parameters::OUT_SIZE_1,
   parameter int          DATA_W       = nn_parameters::DATA_W,
   parameter int          DROP_RATE_Q8 = nn_parameters::DROP_RATE_Q8,
   parameter int          SCALE_Q8     = nn_parameters::SCALE_Q8,
   parameter logic [15:0] LFSR_SEED    = nn_parameters::LFSR_SEED
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     train_en,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] input_vector  [0:OUT_SIZE_1-1],
   output logic        [DATA_W-1:0] output_vector [0:OUT_SIZE_1-1],
   output logic                     out_valid
);

   logic [15:0] lfsr;
   logic signed [DATA_W-1:0] lane_y [0:OUT_SIZE_1-1];
   logic        [7:0]        lane_r [0:OUT_SIZE_1-1];

   for (genvar i = 0; i < OUT_SIZE_1; i++) begin : g_lane
      // Per-lane whitening constant so lanes sharing one LFSR state see different draws.
      localparam logic [7:0] LANE_KEY = 8'(i * 32'h9E37);

      assign lane_r[i] = lfsr[7:0] ^ LANE_KEY;

      dropout_lane #(
         .DATA_W       (DATA_W),
         .DROP_RATE_Q8 (DROP_RATE_Q8),
         .SCALE_Q8     (SCALE_Q8)
      ) u_lane (
         .x        (input_vector[i]),
         .r        (lane_r[i]),
         .train_en (train_en),
         .y        (lane_y[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr      <= LFSR_SEED;
         out_valid <= 1'b0;
         for (int i = 0; i < OUT_SIZE_1; i++)
            output_vector[i] <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            for (int i = 0; i < OUT_SIZE_1; i++)
               output_vector[i] <= lane_y[i];
            if (train_en)
               lfsr <= nn_parameters::lfsr_step(lfsr);
         end
      end
   end

endmodule

// File: tb/tb_nn_dropout_layer_1.sv
// tb/tb_nn_dropout_layer_1.sv - randomized self-checking bench for nn_dropout_layer_1 against a lane-level model
module tb_nn_dropout_layer_1;

   localparam int N = 128;

   logic clk = 1'b0;
   logic rst, train_en, in_valid;
   logic signed [15:0] in_vec [0:N-1];
   logic [15:0] out_a [0:N-1];
   logic [15:0] out_b [0:N-1];
   logic valid_a, valid_b;

   always #5 clk = ~clk;

   nn_dropout_layer_1 dut (
      .clk           (clk),
      .rst           (rst),
      .train_en      (train_en),
      .in_valid      (in_valid),
      .input_vector  (in_vec),
      .output_vector (out_a),
      .out_valid     (valid_a)
   );

   nn_dropout_layer_1 #(.DROP_RATE_Q8(0)) dut_nodrop (
      .clk           (clk),
      .rst           (rst),
      .train_en      (train_en),
      .in_valid      (in_valid),
      .input_vector  (in_vec),
      .output_vector (out_b),
      .out_valid     (valid_b)
   );

   int tests = 0;
   int fails = 0;

   int          m_lfsr;
   logic [15:0] m_a [0:N-1];
   logic [15:0] m_b [0:N-1];
   logic        m_valid;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference lane: y = floor(x * 341 / 256) clamped to 16-bit signed, or 0 when dropped.
   function automatic logic [15:0] model_lane(input int x, input int r, input bit te, input int drop);
      int y;
      if (!te) return 16'(x);
      if (r < drop) return 16'h0000;
      y = (x * 341) >>> 8;
      if (y > 32767) y = 32767;
      if (y < -32768) y = -32768;
      return 16'(y);
   endfunction

   task automatic model_edge();
      int r, lsb;
      if (rst) begin
         m_valid = 1'b0;
         m_lfsr  = 'hACE1;
         for (int i = 0; i < N; i++) begin
            m_a[i] = 16'h0;
            m_b[i] = 16'h0;
         end
      end else begin
         m_valid = in_valid;
         if (in_valid) begin
            for (int i = 0; i < N; i++) begin
               r = (m_lfsr ^ ((i * 'h9E37) & 'hFFFF)) & 'hFF;
               m_a[i] = model_lane(int'(in_vec[i]), r, train_en, 64);
               m_b[i] = model_lane(int'(in_vec[i]), r, train_en, 0);
            end
            if (train_en) begin
               lsb    = m_lfsr & 1;
               m_lfsr = m_lfsr >> 1;
               if (lsb != 0) m_lfsr = m_lfsr ^ 'hB400;
            end
         end
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, "_valid_a"}, 32'(valid_a), 32'(m_valid));
      check({tag, "_valid_b"}, 32'(valid_b), 32'(m_valid));
      for (int i = 0; i < N; i++) begin
         check($sformatf("%s_a%0d", tag, i), 32'(out_a[i]), 32'(m_a[i]));
         check($sformatf("%s_b%0d", tag, i), 32'(out_b[i]), 32'(m_b[i]));
      end
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      compare_all(tag);
   endtask

   task automatic fill(input logic [15:0] v);
      for (int i = 0; i < N; i++) in_vec[i] = v;
   endtask

   task automatic fill_random();
      for (int i = 0; i < N; i++) in_vec[i] = 16'($urandom);
   endtask

   int drops;
   int pct;

   initial begin
      rst = 1'b1; train_en = 1'b0; in_valid = 1'b1;
      fill(16'h7FFF);
      #1;
      step("reset0");
      step("reset1");

      rst = 1'b0; train_en = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < N; i++) in_vec[i] = 16'(i * 3 - 100);
      step("ident");
      check("ident_lane0", 32'(out_a[0]), 32'(16'hFF9C));
      check("ident_lane127", 32'(out_a[127]), 32'(16'd281));
      fill_random();
      step("ident_rand");
      in_valid = 1'b0;
      fill(16'h1234);
      step("ident_hold");

      // LFSR must still be at its seed here, since only identity vectors have been accepted.
      train_en = 1'b1; in_valid = 1'b1;
      fill(16'h0100);
      step("mask");

      fill_random();
      in_vec[0] = 16'sh7000;
      in_vec[1] = 16'sh8000;
      in_vec[2] = 16'sh0100;
      step("sat");
      check("sat_pos", 32'(out_b[0]), 32'(16'h7FFF));
      check("sat_neg", 32'(out_b[1]), 32'(16'h8000));
      check("sat_one", 32'(out_b[2]), 32'(16'h0155));

      for (int k = 0; k < 3; k++) begin
         train_en = 1'($urandom);
         fill_random();
         step("stream");
      end
      in_valid = 1'b0;
      fill_random();
      step("stream_idle0");
      step("stream_idle1");

      in_valid = 1'b1; train_en = 1'b1;
      fill_random();
      step("pre_rst");
      rst = 1'b1;
      step("mid_rst");
      rst = 1'b0;
      fill(16'h0100);
      step("post_rst_mask");

      drops = 0;
      for (int k = 0; k < 100; k++) begin
         step("ratio");
         for (int i = 0; i < N; i++)
            if (out_a[i] == 16'h0) drops++;
      end
      pct = drops * 100 / (100 * N);
      check("drop_pct_in_range", 32'(pct >= 15 && pct <= 35), 32'd1);

      for (int k = 0; k < 60; k++) begin
         rst      = ($urandom_range(0, 19) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         train_en = 1'($urandom);
         fill_random();
         if ($urandom_range(0, 3) == 0) begin
            in_vec[$urandom_range(0, N - 1)] = 16'sh7FFF;
            in_vec[$urandom_range(0, N - 1)] = 16'sh8000;
         end
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
